// File: rtl/serial_argmax_frame_pkg.sv
// Shared sample-range helpers for the framed argmax block.
// No logic here; constants only.
// Bounds are derived from the sample width at the point of use.
package serial_argmax_frame_pkg;

    // Most negative two's complement value for a given sample width
    function automatic int sample_min(input int width);
        return -(1 <<< (width - 1));
    endfunction

    // Most positive two's complement value for a given sample width
    function automatic int sample_max(input int width);
        return (1 <<< (width - 1)) - 1;
    endfunction

endpackage

// File: rtl/serial_argmax_frame_if.sv
// Sample stream in, per-frame result stream out, both valid/ready.
// Pure wiring, no latency.
// in_ready is driven by the block, out_ready by the consumer.
interface serial_argmax_frame_if #(
    parameter int WIDTH     = 4,
    parameter int IDX_WIDTH = 8
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [WIDTH-1:0]     in;
    logic                        in_last;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [WIDTH-1:0]     max;
    logic        [IDX_WIDTH-1:0] max_idx;
    logic        [IDX_WIDTH-1:0] count;
    logic                        ovf;

    // Source/consumer side
    modport master (
        output in_valid, in, in_last, out_ready,
        input  in_ready, out_valid, max, max_idx, count, ovf
    );

    // Reduction block side
    modport slave (
        input  in_valid, in, in_last, out_ready,
        output in_ready, out_valid, max, max_idx, count, ovf
    );
endinterface

// File: rtl/serial_argmax_frame_accum.sv
// Argmax accumulator: running max, first index of max, saturating beat index.
// res_* is combinational and already includes the beat currently offered.
// No backpressure of its own; the caller asserts beat only on an accepted input.
module serial_argmax_frame_accum
    import serial_argmax_frame_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int IDX_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        beat,
    input  logic                        last,
    input  logic signed [WIDTH-1:0]     sample,
    output logic signed [WIDTH-1:0]     res_max,
    output logic        [IDX_WIDTH-1:0] res_idx,
    output logic        [IDX_WIDTH-1:0] res_count,
    output logic                        res_ovf
);
    localparam logic signed [WIDTH-1:0] SAMPLE_MIN = WIDTH'(sample_min(WIDTH));
    localparam logic [IDX_WIDTH-1:0]    IDX_ONES   = '1;

    logic                        first;    // next beat starts a new frame
    logic                        full;     // all-ones index already used in this frame
    logic                        ovf_acc;
    logic signed [WIDTH-1:0]     acc_max;
    logic        [IDX_WIDTH-1:0] acc_idx;
    logic        [IDX_WIDTH-1:0] nxt_idx;
    logic        [IDX_WIDTH-1:0] cur_idx;
    logic                        take;

    // Fold the offered beat into the running result; strict compare keeps earliest index
    always_comb begin
        cur_idx   = first ? '0 : nxt_idx;
        take      = first || (sample > acc_max);
        res_max   = take ? sample : acc_max;
        res_idx   = take ? cur_idx : acc_idx;
        res_count = cur_idx;
        res_ovf   = ovf_acc || (!first && full);
    end

    // Commit accepted beats; a last beat returns everything to the frame-start state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first   <= 1'b1;
            full    <= 1'b0;
            ovf_acc <= 1'b0;
            acc_max <= SAMPLE_MIN;
            acc_idx <= '0;
            nxt_idx <= '0;
        end else if (beat) begin
            if (last) begin
                first   <= 1'b1;
                full    <= 1'b0;
                ovf_acc <= 1'b0;
                acc_max <= SAMPLE_MIN;
                acc_idx <= '0;
                nxt_idx <= '0;
            end else begin
                first   <= 1'b0;
                ovf_acc <= res_ovf;
                acc_max <= res_max;
                acc_idx <= res_idx;
                if (cur_idx == IDX_ONES) begin
                    full    <= 1'b1;
                    nxt_idx <= IDX_ONES;
                end else begin
                    nxt_idx <= cur_idx + IDX_WIDTH'(1);
                end
            end
        end
    end
endmodule

// File: rtl/serial_argmax_frame.sv
// Framed argmax: per frame emits max, first index of max, length-1 and overflow.
// Latency 1 cycle from accepted last beat to out_valid; 1-beat frames run at full rate.
// in_ready drops only while a result is pending and the consumer is not taking it.
module serial_argmax_frame
    import serial_argmax_frame_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int IDX_WIDTH = 8
) (
    input logic                clk,
    input logic                rst,
    serial_argmax_frame_if.slave bus
);
    localparam logic signed [WIDTH-1:0] SAMPLE_MIN = WIDTH'(sample_min(WIDTH));

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t                      state;
    logic                        out_valid_q;
    logic signed [WIDTH-1:0]     max_q;
    logic        [IDX_WIDTH-1:0] max_idx_q;
    logic        [IDX_WIDTH-1:0] count_q;
    logic                        ovf_q;

    logic                        in_ready;
    logic                        accept;
    logic signed [WIDTH-1:0]     res_max;
    logic        [IDX_WIDTH-1:0] res_idx;
    logic        [IDX_WIDTH-1:0] res_count;
    logic                        res_ovf;

    assign in_ready      = !out_valid_q || bus.out_ready;
    assign accept        = bus.in_valid && in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.max       = max_q;
    assign bus.max_idx   = max_idx_q;
    assign bus.count     = count_q;
    assign bus.ovf       = ovf_q;

    serial_argmax_frame_accum #(
        .WIDTH     (WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_accum (
        .clk       (clk),
        .rst       (rst),
        .beat      (accept),
        .last      (bus.in_last),
        .sample    (bus.in),
        .res_max   (res_max),
        .res_idx   (res_idx),
        .res_count (res_count),
        .res_ovf   (res_ovf)
    );

    // Result holding FSM: capture on last beat, hold until consumed, reload on consume+last
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ACCUM;
            out_valid_q <= 1'b0;
            max_q       <= SAMPLE_MIN;
            max_idx_q   <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept && bus.in_last) begin
                        state       <= HOLD;
                        out_valid_q <= 1'b1;
                        max_q       <= res_max;
                        max_idx_q   <= res_idx;
                        count_q     <= res_count;
                        ovf_q       <= res_ovf;
                    end
                end
                HOLD: begin
                    if (accept && bus.in_last) begin
                        // accept in HOLD implies the pending result is being consumed
                        max_q       <= res_max;
                        max_idx_q   <= res_idx;
                        count_q     <= res_count;
                        ovf_q       <= res_ovf;
                    end else if (bus.out_ready) begin
                        state       <= ACCUM;
                        out_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_argmax_frame.sv
// Bench for serial_argmax_frame: directed scenarios plus randomized frames.
// Two instances: IDX_WIDTH=8 (a) and IDX_WIDTH=2 (b, overflow cases).
// Results are compared against a frame-level reference model.
module tb_serial_argmax_frame;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_argmax_frame_if #(.WIDTH(4), .IDX_WIDTH(8)) a_if ();
    serial_argmax_frame_if #(.WIDTH(4), .IDX_WIDTH(2)) b_if ();

    serial_argmax_frame #(.WIDTH(4), .IDX_WIDTH(8)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    serial_argmax_frame #(.WIDTH(4), .IDX_WIDTH(2)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

    typedef struct packed {
        logic signed [3:0] mx;
        logic [7:0]        idx;
        logic [7:0]        cnt;
        logic              ovf;
    } res_t;

    res_t obs_a[$];
    res_t obs_b[$];
    int   tests = 0;
    int   fails = 0;
    bit   rand_ready = 1'b0;

    // Record every result handshake (sampled at negedge, completes at next posedge)
    always @(negedge clk) begin
        if (rst && a_if.out_valid && a_if.out_ready)
            obs_a.push_back(res_t'{a_if.max, a_if.max_idx, a_if.count, a_if.ovf});
        if (rst && b_if.out_valid && b_if.out_ready)
            obs_b.push_back(res_t'{b_if.max, 8'(b_if.max_idx), 8'(b_if.count), b_if.ovf});
    end

    // Random consumer stalls on instance a when enabled
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            a_if.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Frame-level reference: max over the frame, first index, saturated to the index width
    function automatic res_t model(input int v[$], input int iw);
        res_t r;
        int best = v[0];
        int bi   = 0;
        int lim  = (1 << iw) - 1;
        int n    = v.size();
        for (int i = 1; i < n; i++)
            if (v[i] > best) begin
                best = v[i];
                bi   = i;
            end
        r.mx  = 4'(best);
        r.idx = 8'((bi > lim) ? lim : bi);
        r.cnt = 8'((n - 1 > lim) ? lim : n - 1);
        r.ovf = (n > lim + 1);
        return r;
    endfunction

    // Present one beat on a and hold until accepted; leaves in_valid asserted
    task automatic send_beat_a(input logic signed [3:0] v, input logic l);
        int  n  = 0;
        bit  ok = 1'b0;
        a_if.in_valid = 1'b1;
        a_if.in       = v;
        a_if.in_last  = l;
        while (!ok) begin
            @(negedge clk);
            if (a_if.in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
            n++;
            if (!ok && n > 300) begin
                tests++;
                fails++;
                $display("FAIL send_beat_a timeout: in_ready stayed %0b, required 1", a_if.in_ready);
                ok = 1'b1;
            end
        end
    endtask

    task automatic send_beat_b(input logic signed [3:0] v, input logic l);
        int  n  = 0;
        bit  ok = 1'b0;
        b_if.in_valid = 1'b1;
        b_if.in       = v;
        b_if.in_last  = l;
        while (!ok) begin
            @(negedge clk);
            if (b_if.in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
            n++;
            if (!ok && n > 300) begin
                tests++;
                fails++;
                $display("FAIL send_beat_b timeout: in_ready stayed %0b, required 1", b_if.in_ready);
                ok = 1'b1;
            end
        end
    endtask

    task automatic wait_obs_a(input int need);
        int c = 0;
        while (obs_a.size() < need && c < 500) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (obs_a.size() < need) begin
            tests++;
            fails++;
            $display("FAIL wait_obs_a: got %0d results, required %0d", obs_a.size(), need);
        end
    endtask

    task automatic wait_obs_b(input int need);
        int c = 0;
        while (obs_b.size() < need && c < 500) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (obs_b.size() < need) begin
            tests++;
            fails++;
            $display("FAIL wait_obs_b: got %0d results, required %0d", obs_b.size(), need);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        a_if.in_valid = 0; a_if.in = 0; a_if.in_last = 0; a_if.out_ready = 1;
        b_if.in_valid = 0; b_if.in = 0; b_if.in_last = 0; b_if.out_ready = 1;
        #12;
        tests++;
        if (a_if.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b, required 0", a_if.out_valid); end
        tests++;
        if (a_if.max !== 4'sh8) begin fails++; $display("FAIL reset_max: got %0d, required -8", a_if.max); end
        tests++;
        if ({a_if.max_idx, a_if.count, a_if.ovf} !== 17'd0) begin
            fails++; $display("FAIL reset_idx_count_ovf: got %0d/%0d/%0b, required 0/0/0", a_if.max_idx, a_if.count, a_if.ovf);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (a_if.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b, required 1", a_if.in_ready); end
    endtask

    task automatic test_basic();
        int   fr[$] = '{3, -2, 7, 7, 1};
        res_t got;
        res_t exp = res_t'{4'sd7, 8'd2, 8'd4, 1'b0};
        obs_a.delete();
        a_if.out_ready = 1'b1;
        foreach (fr[i]) send_beat_a(4'(fr[i]), i == fr.size() - 1);
        a_if.in_valid = 1'b0;
        wait_obs_a(1);
        if (obs_a.size() > 0) begin
            got = obs_a.pop_front();
            tests++;
            if (got !== exp) begin
                fails++; $display("FAIL basic_frame: got max=%0d idx=%0d cnt=%0d ovf=%0b, required 7/2/4/0", got.mx, got.idx, got.cnt, got.ovf);
            end
        end
    endtask

    task automatic test_ties_and_clear();
        int   f1[$] = '{-8, -8, -8};
        res_t got;
        obs_a.delete();
        foreach (f1[i]) send_beat_a(4'(f1[i]), i == f1.size() - 1);
        send_beat_a(4'sd5, 1'b1);
        a_if.in_valid = 1'b0;
        wait_obs_a(2);
        if (obs_a.size() >= 2) begin
            got = obs_a.pop_front();
            tests++;
            if (got !== res_t'{4'sh8, 8'd0, 8'd2, 1'b0}) begin
                fails++; $display("FAIL ties_min: got max=%0d idx=%0d cnt=%0d ovf=%0b, required -8/0/2/0", got.mx, got.idx, got.cnt, got.ovf);
            end
            got = obs_a.pop_front();
            tests++;
            if (got !== res_t'{4'sd5, 8'd0, 8'd0, 1'b0}) begin
                fails++; $display("FAIL single_after_min: got max=%0d idx=%0d cnt=%0d ovf=%0b, required 5/0/0/0", got.mx, got.idx, got.cnt, got.ovf);
            end
        end
    endtask

    task automatic test_backpressure();
        obs_a.delete();
        a_if.out_ready = 1'b0;
        send_beat_a(4'sd1, 1'b1);
        a_if.in = 4'sd2;
        a_if.in_last = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests++;
            if (a_if.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready cyc%0d: got %0b, required 0", k, a_if.in_ready); end
            tests++;
            if (a_if.out_valid !== 1'b1 || a_if.max !== 4'sd1 || a_if.count !== 8'd0) begin
                fails++; $display("FAIL bp_hold cyc%0d: got valid=%0b max=%0d cnt=%0d, required 1/1/0", k, a_if.out_valid, a_if.max, a_if.count);
            end
            @(posedge clk);
            #1;
        end
        a_if.out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (a_if.in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %0b, required 1", a_if.in_ready); end
        @(posedge clk);
        #1;
        a_if.in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (a_if.out_valid !== 1'b1 || a_if.max !== 4'sd2) begin
            fails++; $display("FAIL bp_next_frame: got valid=%0b max=%0d, required 1/2", a_if.out_valid, a_if.max);
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (obs_a.size() !== 2) begin
            fails++; $display("FAIL bp_result_count: got %0d results, required 2", obs_a.size());
        end else if (obs_a[0].mx !== 4'sd1 || obs_a[1].mx !== 4'sd2) begin
            fails++; $display("FAIL bp_result_order: got %0d,%0d, required 1,2", obs_a[0].mx, obs_a[1].mx);
        end
    endtask

    task automatic test_back_to_back();
        logic signed [3:0] vals [3];
        vals[0] = 4'sd6; vals[1] = -4'sd1; vals[2] = 4'sd0;
        obs_a.delete();
        a_if.out_ready = 1'b1;
        a_if.in_valid  = 1'b1;
        a_if.in_last   = 1'b1;
        a_if.in        = vals[0];
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (k < 2) a_if.in = vals[k + 1];
            else       a_if.in_valid = 1'b0;
            @(negedge clk);
            tests++;
            if (a_if.out_valid !== 1'b1 || a_if.max !== vals[k]) begin
                fails++; $display("FAIL b2b_beat%0d: got valid=%0b max=%0d, required 1/%0d", k, a_if.out_valid, a_if.max, vals[k]);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        tests++;
        if (a_if.out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain: got valid=%0b, required 0", a_if.out_valid); end
        tests++;
        if (obs_a.size() !== 3) begin fails++; $display("FAIL b2b_count: got %0d results, required 3", obs_a.size()); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_overflow();
        int   f1[$] = '{0, 0, 0, 0, 0, 3};
        int   f2[$] = '{1, 2};
        res_t got;
        obs_b.delete();
        foreach (f1[i]) send_beat_b(4'(f1[i]), i == f1.size() - 1);
        foreach (f2[i]) send_beat_b(4'(f2[i]), i == f2.size() - 1);
        b_if.in_valid = 1'b0;
        wait_obs_b(2);
        if (obs_b.size() >= 2) begin
            got = obs_b.pop_front();
            tests++;
            if (got !== res_t'{4'sd3, 8'd3, 8'd3, 1'b1}) begin
                fails++; $display("FAIL ovf_frame: got max=%0d idx=%0d cnt=%0d ovf=%0b, required 3/3/3/1", got.mx, got.idx, got.cnt, got.ovf);
            end
            got = obs_b.pop_front();
            tests++;
            if (got !== res_t'{4'sd2, 8'd1, 8'd1, 1'b0}) begin
                fails++; $display("FAIL ovf_cleared: got max=%0d idx=%0d cnt=%0d ovf=%0b, required 2/1/1/0", got.mx, got.idx, got.cnt, got.ovf);
            end
        end
    endtask

    task automatic test_reset_midframe();
        res_t got;
        obs_a.delete();
        a_if.out_ready = 1'b1;
        send_beat_a(4'sd2, 1'b0);
        send_beat_a(4'sd7, 1'b0);
        a_if.in_valid = 1'b0;
        #1 rst = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        send_beat_a(4'sd4, 1'b1);
        a_if.in_valid = 1'b0;
        wait_obs_a(1);
        if (obs_a.size() > 0) begin
            got = obs_a.pop_front();
            tests++;
            if (got !== res_t'{4'sd4, 8'd0, 8'd0, 1'b0}) begin
                fails++; $display("FAIL rst_midframe: got max=%0d idx=%0d cnt=%0d ovf=%0b, required 4/0/0/0", got.mx, got.idx, got.cnt, got.ovf);
            end
        end
        a_if.out_ready = 1'b0;
        send_beat_a(4'sd3, 1'b1);
        a_if.in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (a_if.out_valid !== 1'b1) begin fails++; $display("FAIL rst_pending_setup: got valid=%0b, required 1", a_if.out_valid); end
        #1 rst = 1'b0;
        #1;
        tests++;
        if (a_if.out_valid !== 1'b0 || a_if.max !== 4'sh8) begin
            fails++; $display("FAIL rst_async: got valid=%0b max=%0d, required 0/-8", a_if.out_valid, a_if.max);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        a_if.out_ready = 1'b1;
        obs_a.delete();
    endtask

    task automatic test_random();
        res_t exp_a[$];
        res_t exp_b[$];
        res_t got;
        int   fr[$];
        logic signed [3:0] s;
        obs_a.delete();
        obs_b.delete();
        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            fr.delete();
            for (int i = 0, n = $urandom_range(1, 8); i < n; i++) begin
                s = 4'($urandom);
                fr.push_back(int'(s));
            end
            exp_a.push_back(model(fr, 8));
            foreach (fr[i]) begin
                send_beat_a(4'(fr[i]), i == fr.size() - 1);
                if ($urandom_range(0, 3) == 0) begin
                    a_if.in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
        end
        a_if.in_valid = 1'b0;
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        a_if.out_ready = 1'b1;
        for (int f = 0; f < 25; f++) begin
            fr.delete();
            for (int i = 0, n = $urandom_range(1, 7); i < n; i++) begin
                s = 4'($urandom);
                fr.push_back(int'(s));
            end
            exp_b.push_back(model(fr, 2));
            foreach (fr[i]) send_beat_b(4'(fr[i]), i == fr.size() - 1);
        end
        b_if.in_valid = 1'b0;
        wait_obs_a(exp_a.size());
        wait_obs_b(exp_b.size());
        foreach (exp_a[i]) begin
            if (obs_a.size() == 0) break;
            got = obs_a.pop_front();
            tests++;
            if (got !== exp_a[i]) begin
                fails++; $display("FAIL rand_a frame%0d: got %0d/%0d/%0d/%0b, required %0d/%0d/%0d/%0b", i,
                    got.mx, got.idx, got.cnt, got.ovf, exp_a[i].mx, exp_a[i].idx, exp_a[i].cnt, exp_a[i].ovf);
            end
        end
        foreach (exp_b[i]) begin
            if (obs_b.size() == 0) break;
            got = obs_b.pop_front();
            tests++;
            if (got !== exp_b[i]) begin
                fails++; $display("FAIL rand_b frame%0d: got %0d/%0d/%0d/%0b, required %0d/%0d/%0d/%0b", i,
                    got.mx, got.idx, got.cnt, got.ovf, exp_b[i].mx, exp_b[i].idx, exp_b[i].cnt, exp_b[i].ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ties_and_clear();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
